// File: rtl/branch_resolve.sv
// Branch resolution queue: in-order record of predictions, checked at execute.
// Optional stats counters enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_push,
    input  logic [31:0] dec_pc,
    input  logic        dec_pred_taken,
    input  logic [31:0] dec_pred_target,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [31:0] past_pc,
    output logic        past_is_branch,
    output logic        past_wrong,
    output logic        past_predicted_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        queue_full,
    output logic        queue_empty,
    output logic        err_underflow
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts
`endif
);

    logic [31:0] pc_q  [4];
    logic        pt_q  [4];
    logic [31:0] tgt_q [4];

    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;

    logic [31:0] past_pc_q;
    logic        past_is_branch_q;
    logic        past_wrong_q;
    logic        past_pt_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        err_underflow_q;

    logic [31:0] head_pc;
    logic        head_pt;
    logic [31:0] head_tgt;
    logic        resolve_ok;
    logic        mispredict;
    logic        pop;
    logic        push_ok;
    logic [31:0] redirect_pc_d;

    assign head_pc  = pc_q[rd_ptr_q];
    assign head_pt  = pt_q[rd_ptr_q];
    assign head_tgt = tgt_q[rd_ptr_q];

    // Resolve/push qualification and pointer/count next state.
    always_comb begin
        resolve_ok = ex_resolve && (count_q != 3'd0);
        mispredict = resolve_ok &&
                     ((ex_taken != head_pt) ||
                      (ex_taken && (ex_target != head_tgt)));
        pop        = resolve_ok && !mispredict;
        push_ok    = dec_push && !mispredict &&
                     ((count_q != 3'd4) || pop);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (mispredict) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
        end
        redirect_pc_d = ex_taken ? ex_target : (head_pc + 32'd1);
    end

    // Entry storage; stale contents are harmless since count gates use.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            pc_q[wr_ptr_q]  <= dec_pc;
            pt_q[wr_ptr_q]  <= dec_pred_taken;
            tgt_q[wr_ptr_q] <= dec_pred_target;
        end
    end

    // Queue control and registered resolve outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q         <= 2'd0;
            wr_ptr_q         <= 2'd0;
            count_q          <= 3'd0;
            past_pc_q        <= 32'd0;
            past_is_branch_q <= 1'b0;
            past_wrong_q     <= 1'b0;
            past_pt_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            err_underflow_q  <= 1'b0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            past_is_branch_q <= resolve_ok;
            past_wrong_q     <= mispredict;
            redirect_valid_q <= mispredict;
            if (resolve_ok) begin
                past_pc_q <= head_pc;
                past_pt_q <= head_pt;
            end
            if (mispredict) begin
                redirect_pc_q <= redirect_pc_d;
            end
            if (ex_resolve && (count_q == 3'd0)) begin
                err_underflow_q <= 1'b1;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] stat_br_q;
    logic [15:0] stat_mp_q;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_br_q <= 16'd0;
            stat_mp_q <= 16'd0;
        end else begin
            if (resolve_ok && (stat_br_q != 16'hFFFF)) begin
                stat_br_q <= stat_br_q + 16'd1;
            end
            if (mispredict && (stat_mp_q != 16'hFFFF)) begin
                stat_mp_q <= stat_mp_q + 16'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

    assign past_pc              = past_pc_q;
    assign past_is_branch       = past_is_branch_q;
    assign past_wrong           = past_wrong_q;
    assign past_predicted_taken = past_pt_q;
    assign redirect_valid       = redirect_valid_q;
    assign redirect_pc          = redirect_pc_q;
    assign queue_full           = (count_q == 3'd4);
    assign queue_empty          = (count_q == 3'd0);
    assign err_underflow        = err_underflow_q;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 dec_push  input  1  decode issues a branch; enqueue its prediction.
REQ-005 dec_pc  input  32  PC of the issuing branch.
REQ-006 dec_pred_taken  input  1  predictor's taken decision for dec_pc.
REQ-007 dec_pred_target  input  32  target used if dec_pred_taken=1.
REQ-008 ex_resolve  input  1  execute resolves the oldest queued branch this cycle.
REQ-009 ex_taken  input  1  actual branch direction.
REQ-010 ex_target  input  32  actual branch target.
REQ-011 past_pc  output  32  PC of the last resolved branch, fed to the predictor.
REQ-012 past_is_branch  output  1  one-cycle strobe: past_* is valid.
REQ-013 past_wrong  output  1  the last resolved branch mispredicted.
REQ-014 past_predicted_taken  output  1  the prediction that was made for past_pc.
REQ-015 redirect_valid  output  1  one-cycle fetch redirect strobe.
REQ-016 redirect_pc  output  32  correct next PC on redirect.
REQ-017 queue_full  output  1  decode must stall branch issue.
REQ-018 queue_empty  output  1  no unresolved branches are queued.
REQ-019 err_underflow  output  1  sticky flag: ex_resolve was asserted while the queue was empty.

Function
REQ-020 The queue SHALL be an in-order FIFO, depth 4, with entries {pc, pred_taken, pred_target}, using 2-bit read/write pointers that wrap 3->0 and a 3-bit count.
REQ-021 A push SHALL be accepted when dec_push=1 and either count<4, or ex_resolve=1 with no mispredict in the same cycle.
REQ-022 A push offered while full with no qualifying pop SHALL be dropped, and the queue SHALL be unchanged.
REQ-023 A resolve SHALL compare the head entry: mispredict = (ex_taken != pred_taken) OR (ex_taken AND ex_target != pred_target).
REQ-024 The edge after a resolve of a non-empty queue SHALL assert past_is_branch=1, past_pc=head.pc, past_predicted_taken=head.pred_taken, past_wrong=mispredict, each for exactly one cycle; past_pc and past_predicted_taken SHALL hold their value otherwise.
REQ-025 On a mispredict, the same edge SHALL assert redirect_valid=1 with redirect_pc = ex_target if ex_taken, else head.pc+1 (PC is word-addressed).
REQ-026 A mispredict SHALL flush every queue entry (count=0, pointers=0), and any same-cycle dec_push SHALL be dropped as wrong-path.
REQ-027 A correct resolve SHALL pop exactly one entry, with redirect_valid=0.
REQ-028 A simultaneous correct pop and push SHALL leave count unchanged.
REQ-029 A resolve with the queue empty SHALL produce no past_* strobe, no redirect, and no state change, and SHALL set err_underflow.
REQ-030 queue_full SHALL equal (count==4) and queue_empty SHALL equal (count==0), both decoded combinationally from registered count.
REQ-031 Latency from ex_resolve to the past_* and redirect outputs SHALL be exactly 1 cycle, with no combinational input-to-output path on past_* or redirect_*.

Reset
REQ-032 On reset=1 at a clock edge: count=0, pointers=0, and all outputs 0 except queue_empty=1; past_pc=0 and redirect_pc=0; err_underflow cleared.
REQ-033 Reset SHALL override push and resolve in the same cycle, and a reset mid-operation SHALL discard all queued entries.

Configuration
REQ-034 With BRANCH_RESOLVE_STATS_EN defined, the block SHALL add outputs stat_branches[15:0] and stat_mispredicts[15:0], which increment per valid resolve and per mispredict respectively, saturate at 16'hFFFF, and reset to 0.
REQ-035 Without BRANCH_RESOLVE_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Push pc=0x10 (pred NT), then resolve ex_taken=0 -> next cycle past_is_branch=1, past_pc=0x10, past_wrong=0, redirect_valid=0, queue_empty=1.
REQ-037 Push pc=0x20 (pred NT), then resolve ex_taken=1, ex_target=0x40 -> past_wrong=1, redirect_valid=1, redirect_pc=0x40.
REQ-038 Push 4 entries; push a 5th with no resolve -> queue_full=1 and the 5th is dropped; then push and correct-resolve together -> count stays 4 and the head is the 2nd entry.
REQ-039 Queue 3 entries, mispredict the head (pred T target 0x80, actual NT, pc=0x30) with a simultaneous push -> redirect_pc=0x31, queue_empty=1 next cycle.
REQ-040 Resolve with the queue empty -> err_underflow=1, past_is_branch=0; assert reset mid-operation with 2 entries queued -> all outputs return to reset values.
REQ-041 With BRANCH_RESOLVE_STATS_EN defined, 3 resolves including 1 mispredict -> stat_branches=3, stat_mispredicts=1.
